// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants, state types and helpers for the Viterbi traceback
package viterbi_pkg;

   localparam int NUM_ST           = 4;
   localparam int TB_DEPTH_DEFAULT = 8;
   localparam int COL_W            = 2 * NUM_ST;

   typedef logic [1:0] st_t;

   typedef enum logic [1:0] {
      S_WRITE = 2'd0,
      S_TRACE = 2'd1,
      S_DONE  = 2'd2
   } tb_state_t;

   // Pick the 2-bit predecessor of trellis state st out of a packed survivor column.
   function automatic st_t col_pick(input logic [COL_W-1:0] col, input st_t st);
      st_t res;
      case (st)
         2'd0:    res = col[1:0];
         2'd1:    res = col[3:2];
         2'd2:    res = col[5:4];
         default: res = col[7:6];
      endcase
      return res;
   endfunction

endpackage

// File: rtl/surv_mem.sv
// rtl/surv_mem.sv - survivor column store, one write port and one combinational read port
module surv_mem
   import viterbi_pkg::*;
#(
   parameter int DEPTH = TB_DEPTH_DEFAULT,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    wr_addr,
   input  logic [COL_W-1:0] wr_col,
   input  logic [AW-1:0]    rd_addr,
   input  st_t              rd_st,
   output st_t              rd_prv
);

   // Contents are always written earlier in the same frame before being read, so no reset.
   logic [COL_W-1:0] mem [DEPTH];

   // Store one survivor column per accepted trellis step.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_col;
      end
   end

   // Combinational lookup of the predecessor of the current traceback state.
   always_comb begin
      rd_prv = col_pick(mem[rd_addr], rd_st);
   end

endmodule

// File: rtl/traceback.sv
// rtl/traceback.sv - Viterbi traceback: stores a frame of survivors, then walks it backwards
module traceback
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = TB_DEPTH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en_tb,
   input  logic [1:0]          prv_st_00,
   input  logic [1:0]          prv_st_01,
   input  logic [1:0]          prv_st_10,
   input  logic [1:0]          prv_st_11,
   input  logic [1:0]          sel_node,
   output logic [TB_DEPTH-1:0] dec_data,
   output logic                dec_valid,
   output logic                busy,
   output logic                ovf
);

   localparam int PTR_W = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TB_DEPTH - 1);

   tb_state_t        state;
   tb_state_t        state_nxt;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   st_t              cur_st;
   st_t              rd_prv;
   logic             accept;
   logic             frame_end;

   surv_mem #(
      .DEPTH (TB_DEPTH),
      .AW    (PTR_W)
   ) u_surv_mem (
      .clk     (clk),
      .we      (accept),
      .wr_addr (wr_ptr),
      .wr_col  ({prv_st_11, prv_st_10, prv_st_01, prv_st_00}),
      .rd_addr (rd_ptr),
      .rd_st   (cur_st),
      .rd_prv  (rd_prv)
   );

   assign frame_end = accept && (wr_ptr == LAST_PTR);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_WRITE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic plus the status outputs, which depend only on the current state.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      busy      = 1'b0;
      dec_valid = 1'b0;
      case (state)
         S_WRITE: begin
            accept = en_tb;
            if (en_tb && (wr_ptr == LAST_PTR)) begin
               state_nxt = S_TRACE;
            end
         end
         S_TRACE: begin
            busy = 1'b1;
            if (rd_ptr == '0) begin
               state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            dec_valid = 1'b1;
            state_nxt = S_WRITE;
         end
         default: begin
            state_nxt = S_WRITE;
         end
      endcase
   end

   // Write pointer advances per accepted column and rewinds when the frame is complete.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (frame_end) begin
         wr_ptr <= '0;
      end else if (accept) begin
         wr_ptr <= wr_ptr + 1'b1;
      end
   end

   // Traceback walk: seed from the best end state, then follow predecessors column by column.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr   <= '0;
         cur_st   <= 2'b00;
         dec_data <= '0;
      end else if (frame_end) begin
         rd_ptr <= LAST_PTR;
         cur_st <= sel_node;
      end else if (state == S_TRACE) begin
         // The state entered at step k carries message bit k in its MSB.
         dec_data[rd_ptr] <= cur_st[1];
         cur_st           <= rd_prv;
         if (rd_ptr != '0) begin
            rd_ptr <= rd_ptr - 1'b1;
         end
      end
   end

   // Sticky flag for any column offered while the traceback cannot take it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (en_tb && busy) begin
         ovf <= 1'b1;
      end
   end

endmodule

// File: tb/tb_traceback.sv
// tb/tb_traceback.sv - scoreboard bench for the traceback block
module tb_traceback;

   localparam int D = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en_tb = 1'b0;
   logic [1:0]   prv_st_00 = 2'b00;
   logic [1:0]   prv_st_01 = 2'b00;
   logic [1:0]   prv_st_10 = 2'b00;
   logic [1:0]   prv_st_11 = 2'b00;
   logic [1:0]   sel_node = 2'b00;
   logic [D-1:0] dec_data;
   logic         dec_valid;
   logic         busy;
   logic         ovf;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      int         due;
      string      name;
   } exp_t;

   exp_t sb[$];

   // Trellis path 00 -> 10 -> 01 -> 10 -> 11 -> 01 -> 00 -> 10 -> 01 for message 1,0,1,1,0,0,1,0.
   logic [1:0] path [0:8] = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0, 2'd2, 2'd1};

   traceback #(.TB_DEPTH(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en_tb     (en_tb),
      .prv_st_00 (prv_st_00),
      .prv_st_01 (prv_st_01),
      .prv_st_10 (prv_st_10),
      .prv_st_11 (prv_st_11),
      .sel_node  (sel_node),
      .dec_data  (dec_data),
      .dec_valid (dec_valid),
      .busy      (busy),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every dec_valid pulse must match the oldest expected frame, both data and timing.
   always @(negedge clk) begin
      if (dec_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_dec_valid actual=%0h required=no_pulse", dec_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_data"}, 32'(dec_data), 32'(e.data));
            check({e.name, "_latency"}, 32'(cyc + 1), 32'(e.due));
         end
      end
   end

   task automatic put_col(input logic en, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] c, input logic [1:0] d, input logic [1:0] s);
      @(negedge clk);
      en_tb     = en;
      prv_st_00 = a;
      prv_st_01 = b;
      prv_st_10 = c;
      prv_st_11 = d;
      sel_node  = s;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         en_tb = 1'b0;
      end
   endtask

   // Sends one frame; the final column is captured at edge cyc+1, so the pulse is due in cycle cyc+1+D+1.
   task automatic frame(input bit zero, input int gap, input bit push, input string name);
      for (int k = 0; k < D; k++) begin
         logic [1:0] col [4];
         for (int s = 0; s < 4; s++) col[s] = 2'b00;
         if (!zero) col[path[k+1]] = path[k];
         put_col(1'b1, col[0], col[1], col[2], col[3], zero ? 2'b00 : 2'b01);
         if (k == D - 1 && push) begin
            exp_t e;
            e.data = zero ? 8'h00 : 8'h4D;
            e.due  = cyc + 1 + D + 1;
            e.name = name;
            sb.push_back(e);
         end
         if (gap > 0 && k < D - 1) idle(gap);
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      idle(1);
      while ((sb.size() != 0 || busy) && n < 40) begin
         idle(1);
         n++;
      end
      check({name, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_dec_valid", 32'(dec_valid), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_dec_data", 32'(dec_data), 32'd0);
      rst_n = 1'b1;

      frame(1'b0, 0, 1'b1, "msg");
      drain("msg");

      frame(1'b0, 1, 1'b1, "gap");
      drain("gap");

      frame(1'b1, 0, 1'b1, "zero");
      drain("zero");
      check("ovf_clear_before_cont", 32'(ovf), 32'd0);

      frame(1'b0, 0, 1'b1, "cont1");
      put_col(1'b1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0);
      @(posedge clk);
      #1;
      check("ovf_set_first_drop", 32'(ovf), 32'd1);
      for (int j = 0; j < D; j++) put_col(1'b1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0);
      frame(1'b0, 0, 1'b1, "cont2");
      drain("cont");
      check("ovf_sticky", 32'(ovf), 32'd1);

      frame(1'b0, 0, 1'b0, "rst");
      idle(1);
      repeat (4) @(negedge clk);
      check("mid_trace_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_dec_data", 32'(dec_data), 32'd0);
      check("mid_rst_ovf", 32'(ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle(12);
      frame(1'b0, 0, 1'b1, "after_rst");
      drain("after_rst");

      frame(1'b1, 0, 1'b1, "b2b1");
      begin
         int n = 0;
         idle(1);
         while (busy && n < 20) begin
            idle(1);
            n++;
         end
         check("b2b_busy_release", 32'(busy), 32'd0);
      end
      frame(1'b0, 0, 1'b1, "b2b2");
      drain("b2b");
      check("b2b_ovf", 32'(ovf), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
